// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed hex display of a selectable debug channel
module seg_scan_display #(
    parameter int N_DIGITS    = 4,
    parameter int N_CH        = 4,
    parameter int DATA_W      = 32,
    parameter int REFRESH_DIV = 100000,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int WIN_W  = 4 * N_DIGITS,
    localparam int PAGES  = DATA_W / WIN_W,
    localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int CNT_W  = $clog2(REFRESH_DIV)
) (
    input  logic                     sys_clk_in,
    input  logic                     reset,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic [PAGE_W-1:0]        page,
    input  logic                     freeze,
    input  logic                     blank_lz,
    output logic [N_DIGITS-1:0]      an,
    output logic [6:0]               bcd,
    output logic                     digit_tick
);
    logic [CNT_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_snap;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_bcd;
    logic [DATA_W-1:0]   w_ch;
    logic [WIN_W-1:0]    w_win;
    logic [3:0]          w_nib;
    logic                w_hi_zero;
    logic                w_blank;
    logic [6:0]          w_seg;

    assign digit_tick = (r_presc == CNT_W'(REFRESH_DIV - 1));
    assign an         = r_an;
    assign bcd        = r_bcd;

    // Channel mux; an unused select code yields zero
    always_comb begin
        w_ch = '0;
        for (int k = 0; k < N_CH; k++)
            if (sel == SEL_W'(k)) w_ch = ch_data[k*DATA_W +: DATA_W];
    end

    // Live page window over the snapshot; out-of-range pages read as zero
    always_comb begin
        w_win = '0;
        for (int p = 0; p < PAGES; p++)
            if (page == PAGE_W'(p)) w_win = r_snap[p*WIN_W +: WIN_W];
    end

    // Pick the current digit nibble and decide leading-zero blanking from the top down
    always_comb begin
        w_nib     = '0;
        w_blank   = 1'b0;
        w_hi_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_hi_zero = w_hi_zero & (w_win[i*4 +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) begin
                w_nib   = w_win[i*4 +: 4];
                w_blank = blank_lz && (i > 0) && w_hi_zero;
            end
        end
    end

    // Hex to seven-segment decode, bit order {g,f,e,d,c,b,a}
    always_comb begin
        case (w_nib)
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h06;
            4'h2: w_seg = 7'h5B;
            4'h3: w_seg = 7'h4F;
            4'h4: w_seg = 7'h66;
            4'h5: w_seg = 7'h6D;
            4'h6: w_seg = 7'h7D;
            4'h7: w_seg = 7'h07;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h6F;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h7C;
            4'hC: w_seg = 7'h39;
            4'hD: w_seg = 7'h5E;
            4'hE: w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    // Prescaler and digit index advance once per refresh slot
    always_ff @(posedge sys_clk_in or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= digit_tick ? '0 : r_presc + 1'b1;
            if (digit_tick) r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Snapshot follows the selected channel unless frozen
    always_ff @(posedge sys_clk_in or posedge reset) begin
        if (reset) r_snap <= '0;
        else if (!freeze) r_snap <= w_ch;
    end

    // Registered digit enable and segment outputs, one cycle behind the index
    always_ff @(posedge sys_clk_in or posedge reset) begin
        if (reset) begin
            r_an  <= '0;
            r_bcd <= '0;
        end else begin
            r_an  <= N_DIGITS'(1) << r_idx;
            r_bcd <= w_blank ? 7'h00 : w_seg;
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed self-checking bench for seg_scan_display
module tb_seg_scan_display;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] ch_data;
    logic [1:0]   sel;
    logic         page;
    logic         freeze;
    logic         blank_lz;
    logic [3:0]   an;
    logic [6:0]   bcd;
    logic         digit_tick;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    seg_scan_display #(.N_DIGITS(4), .N_CH(4), .DATA_W(32), .REFRESH_DIV(4)) dut (
        .sys_clk_in(clk), .reset(rst), .ch_data(ch_data), .sel(sel), .page(page),
        .freeze(freeze), .blank_lz(blank_lz), .an(an), .bcd(bcd), .digit_tick(digit_tick)
    );

    always #5 clk = ~clk;

    // Edges since reset release; digit shown after edge e is ((e-1)/4)%4
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    function automatic logic [6:0] exp_bcd(input logic [31:0] d, input logic pg, input int idx, input logic blz);
        logic [15:0] w;
        w = pg ? d[31:16] : d[15:0];
        if (blz && idx > 0 && (w >> (4 * idx)) == 16'h0) return 7'h00;
        return seg(w[idx*4 +: 4]);
    endfunction

    task automatic test_reset();
        ch_data  = {32'hCAFEBABE, 32'h0F1E2D3C, 32'h9876FEDC, 32'h1234ABCD};
        sel      = 2'd0;
        page     = 1'b0;
        freeze   = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'b0000) begin errors++; $display("FAIL reset_an got %b want 0000", an); end
        checks++; if (bcd !== 7'h00) begin errors++; $display("FAIL reset_bcd got %h want 00", bcd); end
        checks++; if (digit_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", digit_tick); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'b0001) begin errors++; $display("FAIL first_an got %b want 0001", an); end
        checks++; if (bcd !== 7'h3F) begin errors++; $display("FAIL first_bcd got %h want 3F", bcd); end
    endtask

    task automatic test_scan();
        logic [6:0] tbl [4] = '{7'h5E, 7'h39, 7'h7C, 7'h77};
        int ei;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            checks++; if (an !== 4'(1 << ei)) begin errors++; $display("FAIL scan_an cyc=%0d got %b want %b", cyc, an, 4'(1 << ei)); end
            checks++; if (bcd !== tbl[ei]) begin errors++; $display("FAIL scan_bcd cyc=%0d got %h want %h", cyc, bcd, tbl[ei]); end
            checks++; if (digit_tick !== (cyc % 4 == 3)) begin errors++; $display("FAIL scan_tick cyc=%0d got %b", cyc, digit_tick); end
        end
    endtask

    task automatic test_page();
        logic [6:0] tbl [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        int ei;
        page = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            checks++; if (bcd !== tbl[ei]) begin errors++; $display("FAIL page_bcd cyc=%0d got %h want %h", cyc, bcd, tbl[ei]); end
        end
        page = 1'b0;
    endtask

    task automatic test_sel_sweep();
        logic [6:0] e;
        int ei;
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 2; p++) begin
                sel  = 2'(s);
                page = p[0];
                repeat (2) @(negedge clk);
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    ei = ((cyc - 1) / 4) % 4;
                    e  = exp_bcd(ch_data[s*32 +: 32], p[0], ei, 1'b0);
                    checks++; if (bcd !== e) begin errors++; $display("FAIL sel_bcd sel=%0d page=%0d cyc=%0d got %h want %h", s, p, cyc, bcd, e); end
                end
            end
        end
        sel  = 2'd0;
        page = 1'b0;
    endtask

    task automatic test_freeze();
        logic [6:0] e;
        int ei;
        repeat (2) @(negedge clk);
        freeze = 1'b1;
        sel    = 2'd2;
        ch_data[31:0] = 32'hFFFFFFFF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            e  = exp_bcd(32'h1234ABCD, 1'b0, ei, 1'b0);
            checks++; if (bcd !== e) begin errors++; $display("FAIL frozen_bcd cyc=%0d got %h want %h", cyc, bcd, e); end
        end
        page = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            e  = exp_bcd(32'h1234ABCD, 1'b1, ei, 1'b0);
            checks++; if (bcd !== e) begin errors++; $display("FAIL frozen_page_bcd cyc=%0d got %h want %h", cyc, bcd, e); end
        end
        page   = 1'b0;
        freeze = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            e  = exp_bcd(32'h0F1E2D3C, 1'b0, ei, 1'b0);
            checks++; if (bcd !== e) begin errors++; $display("FAIL unfreeze_bcd cyc=%0d got %h want %h", cyc, bcd, e); end
        end
        sel = 2'd0;
        ch_data[31:0] = 32'h1234ABCD;
    endtask

    task automatic test_blank();
        logic [6:0] t1 [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
        logic [6:0] t2 [4] = '{7'h3F, 7'h00, 7'h00, 7'h00};
        int ei;
        ch_data[31:0] = 32'h00000050;
        blank_lz = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            checks++; if (an !== 4'(1 << ei)) begin errors++; $display("FAIL blank_an cyc=%0d got %b want %b", cyc, an, 4'(1 << ei)); end
            checks++; if (bcd !== t1[ei]) begin errors++; $display("FAIL blank50_bcd cyc=%0d got %h want %h", cyc, bcd, t1[ei]); end
        end
        ch_data[31:0] = 32'h0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            checks++; if (bcd !== t2[ei]) begin errors++; $display("FAIL blank0_bcd cyc=%0d got %h want %h", cyc, bcd, t2[ei]); end
        end
        blank_lz = 1'b0;
        ch_data[31:0] = 32'h1234ABCD;
    endtask

    task automatic test_reset_midscan();
        int ei;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 40 && ((cyc / 4) % 4) != 2; t++) @(negedge clk);
        checks++; if (((cyc / 4) % 4) != 2) begin errors++; $display("FAIL midscan_reach cyc=%0d never reached digit 2", cyc); end
        freeze = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (an !== 4'b0000) begin errors++; $display("FAIL midscan_an got %b want 0000", an); end
        checks++; if (bcd !== 7'h00) begin errors++; $display("FAIL midscan_bcd got %h want 00", bcd); end
        checks++; if (digit_tick !== 1'b0) begin errors++; $display("FAIL midscan_tick got %b want 0", digit_tick); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'b0001) begin errors++; $display("FAIL release_an got %b want 0001", an); end
        checks++; if (bcd !== 7'h3F) begin errors++; $display("FAIL release_bcd got %h want 3F", bcd); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ei = ((cyc - 1) / 4) % 4;
            checks++; if (an !== 4'(1 << ei)) begin errors++; $display("FAIL cleared_an cyc=%0d got %b want %b", cyc, an, 4'(1 << ei)); end
            checks++; if (bcd !== 7'h3F) begin errors++; $display("FAIL cleared_snap_bcd cyc=%0d got %h want 3F", cyc, bcd); end
        end
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_page();
        test_sel_sweep();
        test_freeze();
        test_blank();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
